// File: rtl/mac_kbd_responder.sv
// mac_kbd_responder: keyboard-side command responder for the Mac Plus (M0110A) link.
// Buffers MCU key events in a FIFO and answers each Mac command byte with exactly one
// response byte. Optional macro MACKBD_INQ_TIMEOUT_EN makes Inquiry wait up to
// INQ_TIMEOUT en ticks for a key; without it Inquiry behaves like Instant.
module mac_kbd_responder #(
  parameter int         FIFO_AW     = 3,
  parameter int         INQ_TIMEOUT = 2000000,
  parameter logic [7:0] MODEL_ID    = 8'h0B
) (
  input  logic             clk,
  input  logic             _systemReset,
  input  logic             en,
  input  logic             kbd_strobe,
  input  logic [9:0]       kbd_data,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_strobe,
  output logic [7:0]       rsp_data,
  output logic             rsp_strobe,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE = 2'd0, INQ_WAIT = 2'd1, SEND = 2'd2} state_t;

  state_t             state, state_n;
  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic               strobe_prev, prefix_pend;
  logic               ev, full, empty, push_ok, head_valid;
  logic [8:0]         head;
  logic [7:0]         fetch_code, rsp_n;
  logic               fetch_pop, fetch_set_pend;
  logic               do_fetch, load_rsp;
  logic               pop_now, pop_mem, write_now;
  logic               unused_bits;

  assign unused_bits = kbd_data[9];

`ifdef MACKBD_INQ_TIMEOUT_EN
  localparam int TW = (INQ_TIMEOUT > 1) ? $clog2(INQ_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(INQ_TIMEOUT - 1);
  logic [TW-1:0] timer;
  logic          timer_clr;
`endif

  // Any change of the MCU strobe between en samples is one new event.
  assign ev      = en & (kbd_strobe ^ strobe_prev);
  assign full    = (fifo_level == (FIFO_AW+1)'(DEPTH));
  assign empty   = (fifo_level == '0);
  assign push_ok = ev & ~full;

  // An event arriving this tick is visible as head when the FIFO is empty, so a
  // waiting Inquiry can answer on the tick after the push.
  assign head_valid = ~empty | push_ok;
  assign head       = empty ? kbd_data[8:0] : mem[rd_ptr];

  // Key fetch: keypad codes go out as 0x79 first, then the code on the next fetch.
  always_comb begin
    fetch_code     = 8'h7B;
    fetch_pop      = 1'b0;
    fetch_set_pend = 1'b0;
    if (prefix_pend) begin
      fetch_code = head[7:0];
      fetch_pop  = 1'b1;
    end else if (head_valid) begin
      if (head[8]) begin
        fetch_code     = 8'h79;
        fetch_set_pend = 1'b1;
      end else begin
        fetch_code = head[7:0];
        fetch_pop  = 1'b1;
      end
    end
  end

  // Next state and response selection; only en ticks move the machine.
  always_comb begin
    state_n  = state;
    rsp_n    = rsp_data;
    load_rsp = 1'b0;
    do_fetch = 1'b0;
`ifdef MACKBD_INQ_TIMEOUT_EN
    timer_clr = 1'b0;
`endif
    if (en) begin
      case (state)
        IDLE: if (cmd_strobe) begin
          state_n  = SEND;
          load_rsp = 1'b1;
          case (cmd_data)
`ifdef MACKBD_INQ_TIMEOUT_EN
            8'h10: begin state_n = INQ_WAIT; load_rsp = 1'b0; timer_clr = 1'b1; end
            8'h14: begin do_fetch = 1'b1; rsp_n = fetch_code; end
`else
            8'h10, 8'h14: begin do_fetch = 1'b1; rsp_n = fetch_code; end
`endif
            8'h16:   rsp_n = MODEL_ID;
            8'h36:   rsp_n = 8'h7D;
            default: rsp_n = 8'h7B;
          endcase
        end
        INQ_WAIT: begin
`ifdef MACKBD_INQ_TIMEOUT_EN
          if (prefix_pend | head_valid) begin
            do_fetch = 1'b1;
            rsp_n    = fetch_code;
            load_rsp = 1'b1;
            state_n  = SEND;
          end else if (timer == TIMER_LAST) begin
            rsp_n    = 8'h7B;
            load_rsp = 1'b1;
            state_n  = SEND;
          end
`else
          state_n = IDLE;
`endif
        end
        SEND:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign pop_now   = do_fetch & fetch_pop;
  assign pop_mem   = pop_now & ~empty;
  // A bypassed event that is popped on arrival never lands in storage.
  assign write_now = push_ok & ~(pop_now & empty);

  // Control state, FIFO pointers/level and sticky overflow.
  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset) begin
      state       <= IDLE;
      rsp_data    <= 8'h7B;
      strobe_prev <= kbd_strobe;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_level  <= '0;
      overflow    <= 1'b0;
      prefix_pend <= 1'b0;
    end else if (en) begin
      strobe_prev <= kbd_strobe;
      state       <= state_n;
      if (load_rsp) rsp_data <= rsp_n;
      if (ev & full) overflow <= 1'b1;
      if (write_now) wr_ptr <= wr_ptr + 1'b1;
      if (pop_mem) rd_ptr <= rd_ptr + 1'b1;
      case ({write_now, pop_mem})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (do_fetch) prefix_pend <= fetch_set_pend;
    end
  end

  // Event storage; contents need no reset since level/pointers gate reads.
  always_ff @(posedge clk) begin
    if (en && write_now) mem[wr_ptr] <= kbd_data[8:0];
  end

`ifdef MACKBD_INQ_TIMEOUT_EN
  // Inquiry wait timer: cleared on entry, counts en ticks while waiting.
  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset)               timer <= '0;
    else if (en && timer_clr)        timer <= '0;
    else if (en && state == INQ_WAIT) timer <= timer + 1'b1;
  end
`endif

  assign rsp_strobe = en & (state == SEND);

endmodule

// File: tb/tb_mac_kbd_responder.sv
// Scoreboard bench for mac_kbd_responder: stimulus pushes expected {byte, tick},
// a negedge monitor pops and compares whenever rsp_strobe is seen.
module tb_mac_kbd_responder;
  localparam int TO = 40;
`ifdef MACKBD_INQ_TIMEOUT_EN
  localparam int INQ_LAT   = 2;
  localparam int EMPTY_LAT = TO + 1;
`else
  localparam int INQ_LAT   = 1;
  localparam int EMPTY_LAT = 1;
`endif

  logic       clk = 0, rst_n = 0, en = 0;
  logic       kbd_strobe = 0, cmd_strobe = 0;
  logic [9:0] kbd_data = '0;
  logic [7:0] cmd_data = '0;
  logic [7:0] rsp_data;
  logic       rsp_strobe;
  logic [3:0] fifo_level;
  logic       overflow;

  typedef struct { logic [7:0] d; int t; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0, tick_cnt = 0;

  mac_kbd_responder #(.FIFO_AW(3), .INQ_TIMEOUT(TO), .MODEL_ID(8'h0B)) dut (
    .clk(clk), ._systemReset(rst_n), .en(en), .kbd_strobe(kbd_strobe),
    .kbd_data(kbd_data), .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
    .rsp_data(rsp_data), .rsp_strobe(rsp_strobe), .fifo_level(fifo_level),
    .overflow(overflow));

  always #5 clk = ~clk;
  always @(posedge clk) en <= ~en;
  always @(posedge clk) if (en) tick_cnt <= tick_cnt + 1;

  // Monitor: every observed response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rsp_strobe === 1'b1) begin
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got %02h at tick %0d, required no response", rsp_data, tick_cnt);
      end else begin
        e = q.pop_front();
        if (rsp_data !== e.d || tick_cnt !== e.t) begin
          n_err++;
          $display("FAIL rsp: got %02h at tick %0d, required %02h at tick %0d", rsp_data, tick_cnt, e.d, e.t);
        end
      end
    end
  end

  // Advance to the next negedge preceding an en tick.
  task automatic tick();
    @(negedge clk);
    while (en !== 1'b1) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic expect_rsp(input logic [7:0] d, input int lat);
    exp_t e;
    e.d = d;
    e.t = tick_cnt + lat;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin tick(); k++; end
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_timeout: got no response, required %0d pending", q.size());
      q.delete();
    end
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] d, input int lat);
    expect_rsp(d, lat);
    cmd_data = c; cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    wait_drain();
    tick();
  endtask

  task automatic event_in(input logic [9:0] d);
    kbd_data = d;
    kbd_strobe = ~kbd_strobe;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with strobe high: no event should appear when reset releases.
    kbd_strobe = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rsp_data", 16'(rsp_data), 16'h7B);
    check("rst_rsp_strobe", 16'(rsp_strobe), 16'h0);
    check("rst_level", 16'(fifo_level), 16'h0);
    check("rst_overflow", 16'(overflow), 16'h0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("no_spurious_event", 16'(fifo_level), 16'h0);

    send_cmd(8'h16, 8'h0B, 1);
    send_cmd(8'h36, 8'h7D, 1);
    send_cmd(8'h55, 8'h7B, 1);

    event_in(10'h033);
    check("level_after_033", 16'(fifo_level), 16'h1);
    send_cmd(8'h14, 8'h33, 1);
    check("level_after_instant", 16'(fifo_level), 16'h0);
    send_cmd(8'h14, 8'h7B, 1);

    send_cmd(8'h10, 8'h7B, EMPTY_LAT);

`ifdef MACKBD_INQ_TIMEOUT_EN
    cmd_data = 8'h10; cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    repeat (10) tick();
    expect_rsp(8'hB2, 1);
    event_in(10'h0B2);
    wait_drain();
    tick();
`else
    send_cmd(8'h10, 8'h7B, 1);
    event_in(10'h0B2);
    send_cmd(8'h14, 8'hB2, 1);
`endif
    check("level_after_b2", 16'(fifo_level), 16'h0);

    event_in(10'h11D);
    check("level_keypad_in", 16'(fifo_level), 16'h1);
    send_cmd(8'h10, 8'h79, INQ_LAT);
    check("level_after_prefix", 16'(fifo_level), 16'h1);
    send_cmd(8'h10, 8'h1D, INQ_LAT);
    check("level_after_keypad", 16'(fifo_level), 16'h0);

    check("overflow_clear", 16'(overflow), 16'h0);
    for (int i = 1; i <= 9; i++) event_in(10'(i));
    check("level_full", 16'(fifo_level), 16'h8);
    check("overflow_set", 16'(overflow), 16'h1);
    for (int i = 1; i <= 8; i++) send_cmd(8'h14, 8'(i), 1);
    check("level_drained", 16'(fifo_level), 16'h0);
    send_cmd(8'h14, 8'h7B, 1);
    check("overflow_sticky", 16'(overflow), 16'h1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
